// File: rtl/usi_backlight_pwm.sv
// USI-bus slave driving the LCD backlight PWM pin. Software sets period, target duty
// and fade rate; the applied duty ramps toward the target only at period boundaries.
module usi_backlight_pwm #(
  parameter int                       pBlockAdrsMap = 8,
  parameter logic [pBlockAdrsMap-1:0] pAdrsMap      = 8'h02,
  parameter int                       pBusAdrsBit   = 16,
  parameter int                       pCntBit       = 16,
  parameter int                       pDefPeriod    = 1000
) (
  input  logic                   iSysClk,
  input  logic                   iSysRst,
  input  logic [31:0]            iSUsiWd,
  input  logic [pBusAdrsBit-1:0] iSUsiAdrs,
  input  logic                   iSUsiWCke,
  output logic [31:0]            oSUsiRd,
  output logic                   oSUsiVd,
  output logic                   oPwm
);

  localparam int cOfsBit = pBusAdrsBit - pBlockAdrsMap;

  localparam logic [cOfsBit-1:0] cOfsCtrl     = cOfsBit'(8'h00);
  localparam logic [cOfsBit-1:0] cOfsPeriod   = cOfsBit'(8'h04);
  localparam logic [cOfsBit-1:0] cOfsTarget   = cOfsBit'(8'h08);
  localparam logic [cOfsBit-1:0] cOfsFadeStep = cOfsBit'(8'h0C);
  localparam logic [cOfsBit-1:0] cOfsStatus   = cOfsBit'(8'h10);

  logic               enReg;
  logic               fadeEnReg;
  logic [pCntBit-1:0] periodReg;
  logic [pCntBit-1:0] targetReg;
  logic [pCntBit-1:0] fadeStepReg;
  logic [pCntBit-1:0] cnt;
  logic [pCntBit-1:0] duty;
  logic [pCntBit-1:0] fadeCnt;

  logic               hit;
  logic [cOfsBit-1:0] ofs;
  logic               wrEn;
  logic               rdEn;
  logic [31:0]        rdData;
  logic               active;
  logic               boundary;
  logic               unusedWdBits;

  assign hit    = (iSUsiAdrs[pBusAdrsBit-1 -: pBlockAdrsMap] == pAdrsMap);
  assign ofs    = iSUsiAdrs[cOfsBit-1:0];
  assign wrEn   = hit && iSUsiWCke;
  assign rdEn   = hit && !iSUsiWCke;

  // Fields narrower than the bus simply drop the upper write-data bits.
  assign unusedWdBits = ^iSUsiWd[31:pCntBit];

  assign active   = enReg && (periodReg != '0);
  // >= rather than == so a PERIOD shrunk below the running count still wraps.
  assign boundary = active && (cnt >= periodReg - pCntBit'(1));

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    rdData = '0;
    case (ofs)
      cOfsCtrl:     rdData[1:0]         = {fadeEnReg, enReg};
      cOfsPeriod:   rdData[pCntBit-1:0] = periodReg;
      cOfsTarget:   rdData[pCntBit-1:0] = targetReg;
      cOfsFadeStep: rdData[pCntBit-1:0] = fadeStepReg;
      cOfsStatus: begin
        rdData[pCntBit-1:0] = duty;
        rdData[31]          = (duty != targetReg);
      end
      default:      rdData = '0;
    endcase
  end

  // Bus register file and read port.
  always_ff @(posedge iSysClk) begin
    // NOTE: reset is synchronous here, so it is simply the highest-priority branch sampled on the clock edge.
    if (iSysRst) begin
      enReg       <= 1'b0;
      fadeEnReg   <= 1'b0;
      periodReg   <= pCntBit'(pDefPeriod);
      targetReg   <= '0;
      fadeStepReg <= '0;
      oSUsiRd     <= '0;
      oSUsiVd     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values, which is what lets a write and a boundary coincide cleanly.
      if (wrEn) begin
        case (ofs)
          cOfsCtrl:     {fadeEnReg, enReg} <= iSUsiWd[1:0];
          cOfsPeriod:   periodReg          <= iSUsiWd[pCntBit-1:0];
          cOfsTarget:   targetReg          <= iSUsiWd[pCntBit-1:0];
          cOfsFadeStep: fadeStepReg        <= iSUsiWd[pCntBit-1:0];
          default:      ;
        endcase
      end
      oSUsiVd <= rdEn;
      oSUsiRd <= rdEn ? rdData : '0;
    end
  end

  // Period counter, duty ramp and PWM output.
  always_ff @(posedge iSysClk) begin
    if (iSysRst) begin
      cnt     <= '0;
      duty    <= '0;
      fadeCnt <= '0;
      oPwm    <= 1'b0;
    end else begin
      if (!active) begin
        cnt     <= '0;
        fadeCnt <= '0;
      end else if (boundary) begin
        cnt <= '0;
        if (!fadeEnReg) begin
          duty    <= targetReg;
          fadeCnt <= '0;
        end else if (fadeCnt == fadeStepReg) begin
          fadeCnt <= '0;
          if (duty < targetReg)      duty <= duty + pCntBit'(1);
          else if (duty > targetReg) duty <= duty - pCntBit'(1);
        end else begin
          fadeCnt <= fadeCnt + pCntBit'(1);
        end
      end else begin
        cnt <= cnt + pCntBit'(1);
      end
      oPwm <= active && (cnt < duty);
    end
  end

endmodule

// File: tb/tb_usi_backlight_pwm.sv
// Scoreboard bench for usi_backlight_pwm: reads push expected data into a queue that a
// monitor drains against the registered read port; PWM waveforms are checked directly.
module tb_usi_backlight_pwm;

  logic        iSysClk = 1'b0;
  logic        iSysRst;
  logic [31:0] iSUsiWd;
  logic [15:0] iSUsiAdrs;
  logic        iSUsiWCke;
  logic [31:0] oSUsiRd;
  logic        oSUsiVd;
  logic        oPwm;

  typedef struct packed {
    logic        vd;
    logic [31:0] rd;
  } rdExp_t;

  rdExp_t sbQ[$];
  int     nChecks = 0;
  int     nFails  = 0;
  logic   reqFlag = 1'b0;
  logic   pend    = 1'b0;
  logic   monOn   = 1'b0;

  localparam logic [15:0] aCtrl     = 16'h0200;
  localparam logic [15:0] aPeriod   = 16'h0204;
  localparam logic [15:0] aTarget   = 16'h0208;
  localparam logic [15:0] aFadeStep = 16'h020C;
  localparam logic [15:0] aStatus   = 16'h0210;

  usi_backlight_pwm dut (
    .iSysClk   (iSysClk),
    .iSysRst   (iSysRst),
    .iSUsiWd   (iSUsiWd),
    .iSUsiAdrs (iSUsiAdrs),
    .iSUsiWCke (iSUsiWCke),
    .oSUsiRd   (oSUsiRd),
    .oSUsiVd   (oSUsiVd),
    .oPwm      (oPwm)
  );

  always #5 iSysClk = ~iSysClk;

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s actual=0x%0h expected=0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge iSysClk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic goIdle();
    iSUsiAdrs = 16'hFF00;
    iSUsiWd   = '0;
    iSUsiWCke = 1'b0;
    reqFlag   = 1'b0;
  endtask

  task automatic busWrite(input logic [15:0] a, input logic [31:0] d);
    iSUsiAdrs = a;
    iSUsiWd   = d;
    iSUsiWCke = 1'b1;
    reqFlag   = 1'b0;
    tick();
    goIdle();
  endtask

  task automatic busRead(input logic [15:0] a, input logic expVd, input logic [31:0] expRd);
    iSUsiAdrs = a;
    iSUsiWCke = 1'b0;
    reqFlag   = 1'b1;
    sbQ.push_back('{vd: expVd, rd: expRd});
    tick();
    goIdle();
  endtask

  task automatic sampleBits(input int n, output logic [31:0] bits);
    bits = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge iSysClk);
      bits[i] = oPwm;
    end
  endtask

  // Bounded search for a rising edge of oPwm, then capture 20 samples from it.
  task automatic captureFromRise(output logic found, output logic [31:0] bits);
    logic prev;
    found = 1'b0;
    bits  = '0;
    @(negedge iSysClk);
    prev = oPwm;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge iSysClk);
      if (oPwm && !prev) found = 1'b1;
      else prev = oPwm;
    end
    if (found) begin
      bits[0] = 1'b1;
      for (int i = 1; i < 20; i++) begin
        @(negedge iSysClk);
        bits[i] = oPwm;
      end
    end
  endtask

  // Read-port monitor: a sampled read request must be answered on the next cycle.
  always @(posedge iSysClk) pend <= reqFlag;

  always @(negedge iSysClk) begin : monitor
    rdExp_t e;
    if (monOn) begin
      if (pend) begin
        if (sbQ.size() == 0) begin
          nChecks++;
          nFails++;
          $display("FAIL sb_underflow actual=empty expected=entry @%0t", $time);
        end else begin
          e = sbQ.pop_front();
          check("rd_vd", {31'b0, oSUsiVd}, {31'b0, e.vd});
          check("rd_data", oSUsiRd, e.rd);
        end
      end else begin
        check("idle_vd", {31'b0, oSUsiVd}, 32'h0);
      end
    end
  end

  logic [31:0] fadeExp [17] = '{
    32'h8000_0000, 32'h8000_0001, 32'h8000_0001, 32'h8000_0002, 32'h8000_0002,
    32'h8000_0001, 32'h8000_0001, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
    32'h8000_0000, 32'h8000_0001, 32'h8000_0001, 32'h8000_0002, 32'h8000_0002,
    32'h0000_0003, 32'h0000_0003
  };

  initial begin
    logic [31:0] bits;
    logic        found;

    iSysRst = 1'b1;
    goIdle();
    idle(2);
    iSysRst = 1'b0;
    monOn   = 1'b1;
    @(negedge iSysClk);
    check("rst_pwm", {31'b0, oPwm}, 32'h0);

    // Reset values, unmapped offset, foreign block, truncation and unused bits.
    busRead(aPeriod, 1'b1, 32'h0000_03E8);
    busRead(16'h0214, 1'b1, 32'h0);
    busRead(16'h0304, 1'b0, 32'h0);
    busRead(aTarget, 1'b1, 32'h0);
    busWrite(aFadeStep, 32'h0012_3456);
    busRead(aFadeStep, 1'b1, 32'h0000_3456);
    busWrite(aCtrl, 32'hFFFF_FFFF);
    busRead(aCtrl, 1'b1, 32'h0000_0003);
    busWrite(aCtrl, 32'h0);

    // Steady 3-high / 7-low waveform.
    busWrite(aPeriod, 32'd10);
    busWrite(aTarget, 32'd3);
    busWrite(aCtrl, 32'h1);
    captureFromRise(found, bits);
    check("t2_rise_found", {31'b0, found}, 32'h1);
    check("t2_pattern", bits & 32'h000F_FFFF, 32'h0000_1C07);
    busRead(aStatus, 1'b1, 32'h0000_0003);

    // Duty above period, PERIOD=0 freeze, duty zero.
    busWrite(aTarget, 32'd12);
    idle(15);
    sampleBits(20, bits);
    check("t3_const_high", bits & 32'h000F_FFFF, 32'h000F_FFFF);
    busRead(aStatus, 1'b1, 32'h0000_000C);
    busWrite(aPeriod, 32'd0);
    idle(2);
    sampleBits(20, bits);
    check("t3_period0_low", bits & 32'h000F_FFFF, 32'h0);
    busWrite(aTarget, 32'd5);
    idle(3);
    busRead(aStatus, 1'b1, 32'h8000_000C);
    busWrite(aTarget, 32'd0);
    busWrite(aPeriod, 32'd10);
    idle(15);
    sampleBits(20, bits);
    check("t3_const_low", bits & 32'h000F_FFFF, 32'h0);
    busRead(aStatus, 1'b1, 32'h0);

    // Fade ramp: STATUS read two cycles after each boundary of a 4-cycle period.
    busWrite(aCtrl, 32'h0);
    busWrite(aPeriod, 32'd4);
    busWrite(aFadeStep, 32'd1);
    busWrite(aTarget, 32'd3);
    busWrite(aCtrl, 32'h3);
    idle(5);
    for (int k = 0; k < 17; k++) begin
      busRead(aStatus, 1'b1, fadeExp[k]);
      if (k == 3)      busWrite(aTarget, 32'd0);
      else if (k == 9) busWrite(aTarget, 32'd3);
      else             tick();
      idle(2);
    end

    // Disable mid-period with duty 8, then restart from cnt=0.
    busWrite(aCtrl, 32'h0);
    busWrite(aPeriod, 32'd10);
    busWrite(aTarget, 32'd8);
    busWrite(aCtrl, 32'h1);
    idle(25);
    @(negedge iSysClk);
    check("t5_pwm_before_off", {31'b0, oPwm}, 32'h1);
    busWrite(aCtrl, 32'h0);
    sampleBits(2, bits);
    check("t5_pwm_off", {31'b0, bits[1]}, 32'h0);
    idle(3);
    busRead(aStatus, 1'b1, 32'h0000_0008);
    busWrite(aCtrl, 32'h1);
    sampleBits(12, bits);
    check("t5_restart", bits & 32'h0000_0FFF, 32'h0000_09FE);

    // Foreign-block write ignored; reset mid-fade beats a coincident write.
    busWrite(16'h0308, 32'd7);
    busRead(aTarget, 1'b1, 32'h0000_0008);
    busWrite(aCtrl, 32'h0);
    busWrite(aPeriod, 32'd4);
    busWrite(aFadeStep, 32'd0);
    busWrite(aTarget, 32'd10);
    busWrite(aCtrl, 32'h3);
    idle(9);
    iSysRst   = 1'b1;
    iSUsiAdrs = aTarget;
    iSUsiWd   = 32'h55;
    iSUsiWCke = 1'b1;
    tick();
    iSysRst = 1'b0;
    goIdle();
    @(negedge iSysClk);
    check("t6_rst_pwm", {31'b0, oPwm}, 32'h0);
    check("t6_rst_vd", {31'b0, oSUsiVd}, 32'h0);
    busRead(aCtrl, 1'b1, 32'h0);
    busRead(aPeriod, 1'b1, 32'h0000_03E8);
    busRead(aTarget, 1'b1, 32'h0);
    busRead(aFadeStep, 1'b1, 32'h0);
    busRead(aStatus, 1'b1, 32'h0);
    sampleBits(8, bits);
    check("t6_pwm_idle", bits & 32'h0000_00FF, 32'h0);

    idle(3);
    check("sb_drain", sbQ.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/usi_backlight_pwm.md
Name: usi_backlight_pwm

Overview:
USI-bus slave that drives the LCD backlight PWM pin, downstream of the USI bus on the system clock. Software writes period, target duty and fade rate over USI. The block generates a glitch-free PWM and ramps the applied duty toward the target, one count at a time. It returns register contents on the USI read path.

Parameters:
pBlockAdrsMap, 8, width of the block-select field in the bus address.
pAdrsMap, 8'h02, block-select value this slave answers to.
pBusAdrsBit, 16, USI address width.
pCntBit, 16, width of the period, duty and fade counters.
pDefPeriod, 1000, reset value of PERIOD.

Ports:
iSysClk  in  1  system clock; the only clock.
iSysRst  in  1  synchronous active-high reset.
iSUsiWd  in  32  write data from USI.
iSUsiAdrs  in  pBusAdrsBit  bus address. [15:8] selects the block; [7:0] is the register offset.
iSUsiWCke  in  1  write strobe, one cycle per write.
oSUsiRd  out  32  read data.
oSUsiVd  out  1  read data valid.
oPwm  out  1  backlight PWM output.

Behaviour:
- Decode: hit when iSUsiAdrs[pBusAdrsBit-1 -: pBlockAdrsMap] == pAdrsMap.
- Register map (byte offsets):
  - 0x00 CTRL: bit0 EN, bit1 FADE_EN.
  - 0x04 PERIOD [pCntBit-1:0].
  - 0x08 TARGET [pCntBit-1:0].
  - 0x0C FADESTEP [pCntBit-1:0].
  - 0x10 STATUS (read-only): [pCntBit-1:0] current duty, bit31 BUSY = (current duty != TARGET).
- Write: hit and iSUsiWCke=1 → register updated at that clock edge. Writes to STATUS or unmapped offsets are ignored. Write data wider than the field is truncated.
- Read: every cycle with hit and iSUsiWCke=0, register oSUsiRd to the selected register and set oSUsiVd=1, at 1-cycle latency.
  - Unmapped offset → Rd=0, Vd=1.
  - No hit, or a write cycle → Rd=0, Vd=0.
  - Unused bits read 0.
- Reset values: CTRL=0, PERIOD=pDefPeriod, TARGET=0, FADESTEP=0, cnt=0, duty=0, fadecnt=0, oPwm=0, oSUsiRd=0, oSUsiVd=0.
- Period counter cnt, while EN=1 and PERIOD!=0:
  - increments each cycle.
  - At cnt >= PERIOD-1 (the boundary), cnt ← 0.
  - The >= compare covers PERIOD being shrunk mid-period below cnt; the wrap then happens on the next cycle.
- Output: oPwm registered, oPwm ← EN && PERIOD!=0 && (cnt < duty).
  - duty >= PERIOD → constant high.
  - duty=0 → constant low.
- Duty update happens only at the boundary, never mid-period:
  - FADE_EN=0: duty ← TARGET.
  - FADE_EN=1:
    - If fadecnt == FADESTEP: fadecnt ← 0 and duty moves one step toward TARGET (±1, none if equal).
    - Otherwise fadecnt ← fadecnt+1.
    - The effective step is therefore 1 count per (FADESTEP+1) periods.
  - A TARGET change mid-fade redirects the ramp at the next step; no overshoot.
  - Clearing FADE_EN mid-fade makes duty jump to TARGET at the next boundary.
- EN=0 (written mid-period):
  - next edge: cnt ← 0, fadecnt ← 0, oPwm ← 0 on the following edge; duty retained.
  - Re-enable starts from cnt=0.
- PERIOD=0: cnt held 0, oPwm=0, no boundaries.
- Simultaneous bus write and boundary: the boundary logic uses the register value from before the edge; the new value applies from the next boundary.
- iSysRst mid-operation: all state returns to reset values on that edge, overriding any coincident write.
- Small design: two counters, one ramp register, mux/decode. No FSM beyond the enable/fade control above.

Test Plan:
1. After reset, read offset 0x04 at address 0x0204 → one cycle later Rd=1000 (0x3E8), Vd=1. Read 0x0214 (unmapped) → Rd=0, Vd=1. Read 0x0304 → Vd=0.
2. PERIOD=10, TARGET=3, CTRL=0x1 → after the first boundary oPwm repeats 3 cycles high / 7 low. STATUS reads duty=3, BUSY=0.
3. PERIOD=10: TARGET=12 → oPwm constant 1 from the next boundary. TARGET=0 → constant 0. PERIOD=0 → oPwm=0 and cnt frozen.
4. PERIOD=4, FADESTEP=1, CTRL=0x3, TARGET=3 from duty 0 → duty 1,1,2,2,3 on successive boundaries (one step every 2 periods). BUSY=1 until duty=3, then 0. TARGET=0 mid-ramp at duty=2 → ramps down 2→1→0 with no overshoot.
5. Write CTRL=0 at cnt=5 with PERIOD=10 and duty=8 → oPwm=0 within 2 cycles and STATUS duty still 8. Write CTRL=1 → cnt restarts at 0 and oPwm high for cycles 0–7.
6. Write to 0x0308 (other block) → TARGET unchanged. Assert iSysRst for one cycle mid-fade with a simultaneous write → all registers at reset values, oPwm=0, oSUsiVd=0.
